// File: rtl/nx1_pkg.sv
// Shared definitions for the X1 GRAM access path: plane codes, area-to-plane
// mask tables, sequencer state encoding and the memory beat payload.
package nx1_pkg;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 3;

  localparam logic [1:0] PL_B = 2'b01;
  localparam logic [1:0] PL_R = 2'b10;
  localparam logic [1:0] PL_G = 2'b11;

  // Plane masks {G,R,B} indexed by area I_A[15:14]; area 00 is not GRAM
  localparam logic [3:0][MW-1:0] MASK_NRM = {3'b100, 3'b010, 3'b001, 3'b000};
  localparam logic [3:0][MW-1:0] MASK_DAM = {3'b011, 3'b101, 3'b110, 3'b000};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WBEAT,
    ST_RBEAT,
    ST_DONE
  } gram_state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } gram_beat_t;

  // Plane code of the lowest pending mask bit, served in order B, R, G
  function automatic logic [1:0] low_plane(input logic [MW-1:0] mask);
    if (mask[0])      return PL_B;
    else if (mask[1]) return PL_R;
    else if (mask[2]) return PL_G;
    else              return 2'b00;
  endfunction

  function automatic logic [MW-1:0] low_bit(input logic [MW-1:0] mask);
    return mask & (~mask + MW'(1));
  endfunction

endpackage

// File: rtl/nx1_gram_beat_ctl.sv
// One GRAM beat: holds REQ and the beat payload until ACK, with a saturating
// per-beat wait counter that aborts the beat after MAX_BEAT_WAIT cycles.
module nx1_gram_beat_ctl
  import nx1_pkg::*;
#(
  parameter int unsigned MAX_BEAT_WAIT = 255
) (
  input  logic       C_CLK,
  input  logic       I_RESET_n,
  input  logic       start,
  input  gram_beat_t beat,
  input  logic       ack,
  output logic       req,
  output gram_beat_t beat_q,
  output logic       done_c,
  output logic       tmo_c
);

  localparam int unsigned CW = 8;
  localparam logic TMO_EN = (MAX_BEAT_WAIT != 0);

  logic [CW-1:0] cnt_q;
  logic [CW:0]   cnt_inc_c;

  assign cnt_inc_c = {1'b0, cnt_q} + (CW+1)'(1);
  assign done_c    = req & ack;
  assign tmo_c     = req & ~ack & TMO_EN & (32'(cnt_inc_c) >= MAX_BEAT_WAIT);

  always_ff @(posedge C_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      req    <= 1'b0;
      beat_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      req    <= 1'b1;
      beat_q <= beat;
      cnt_q  <= '0;
    end else if (req) begin
      if (ack || tmo_c) begin
        req <= 1'b0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nx1_gram_access.sv
// GRAM I/O access sequencer: turns Z80 I/O strobes into serial plane beats
// (two beats for DAM writes) and stalls the CPU meanwhile.
// Optional macro NX1_DAM_CLR_ON_READ_EN: pulse O_DAM_CLR after each GRAM read.
module nx1_gram_access
  import nx1_pkg::*;
#(
  parameter int unsigned MAX_BEAT_WAIT = 255,
  parameter int unsigned WAIT_LEAD     = 1
) (
  input  logic          C_CLK,
  input  logic          I_RESET_n,
  input  logic [AW-1:0] I_A,
  input  logic [DW-1:0] I_D,
  input  logic          I_IOWR,
  input  logic          I_IORD,
  input  logic          I_DAM,
  output logic          O_WAIT,
  output logic [DW-1:0] O_Q,
  output logic          O_Q_VLD,
  output logic          O_DAM_CLR,
  output logic          O_GRAM_REQ,
  output logic          O_GRAM_WE,
  output logic [AW-1:0] O_GRAM_A,
  output logic [DW-1:0] O_GRAM_D,
  input  logic          I_GRAM_ACK,
  input  logic [DW-1:0] I_GRAM_Q,
  output logic          O_TMO
);

  localparam logic LEAD_EN = (WAIT_LEAD != 0);

  gram_state_t   state_q, state_nxt;
  logic [MW-1:0] mask_q, mask_nxt;
  logic [13:0]   addr_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] q_q, q_nxt;
  logic          q_vld_q, q_vld_nxt;
  logic          tmo_q, wait_q;
  logic          is_gram_c, wr_acc_c, rd_acc_c;
  logic          start_c, done_c, tmo_c, req;
  gram_beat_t    beat_c, beat_q;

  // Strobes are only taken in IDLE; write wins over a simultaneous read
  assign is_gram_c = (I_A[15:14] != 2'b00);
  assign wr_acc_c  = (state_q == ST_IDLE) & I_IOWR & is_gram_c;
  assign rd_acc_c  = (state_q == ST_IDLE) & I_IORD & ~I_IOWR & is_gram_c;

  always_comb begin
    state_nxt = state_q;
    mask_nxt  = mask_q;
    start_c   = 1'b0;
    beat_c    = '0;
    q_nxt     = q_q;
    q_vld_nxt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_acc_c) begin
          mask_nxt    = I_DAM ? MASK_DAM[I_A[15:14]] : MASK_NRM[I_A[15:14]];
          start_c     = 1'b1;
          beat_c.we   = 1'b1;
          beat_c.a    = {low_plane(mask_nxt), I_A[13:0]};
          beat_c.d    = I_D;
          state_nxt   = ST_WBEAT;
        end else if (rd_acc_c) begin
          start_c     = 1'b1;
          beat_c.a    = {low_plane(MASK_NRM[I_A[15:14]]), I_A[13:0]};
          state_nxt   = ST_RBEAT;
        end
      end
      ST_WBEAT: begin
        if (done_c) begin
          mask_nxt = mask_q & ~low_bit(mask_q);
          if (mask_nxt == '0) state_nxt = ST_DONE;
        end else if (tmo_c) begin
          mask_nxt  = '0;
          state_nxt = ST_DONE;
        end else if (!req) begin
          // REQ idled for one cycle after the previous ACK; launch next plane
          start_c   = 1'b1;
          beat_c.we = 1'b1;
          beat_c.a  = {low_plane(mask_q), addr_q};
          beat_c.d  = data_q;
        end
      end
      ST_RBEAT: begin
        if (done_c) begin
          q_nxt     = I_GRAM_Q;
          q_vld_nxt = 1'b1;
          state_nxt = ST_DONE;
        end else if (tmo_c) begin
          q_nxt     = 8'hFF;
          q_vld_nxt = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge C_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      q_q     <= '0;
      q_vld_q <= 1'b0;
      tmo_q   <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      mask_q  <= mask_nxt;
      if (wr_acc_c) begin
        addr_q <= I_A[13:0];
        data_q <= I_D;
      end
      q_q     <= q_nxt;
      q_vld_q <= q_vld_nxt;
      tmo_q   <= tmo_q | tmo_c;
      wait_q  <= (state_nxt != ST_IDLE);
    end
  end

`ifdef NX1_DAM_CLR_ON_READ_EN
  logic dam_clr_q;
  always_ff @(posedge C_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) dam_clr_q <= 1'b0;
    else            dam_clr_q <= rd_acc_c;
  end
  assign O_DAM_CLR = dam_clr_q;
`else
  assign O_DAM_CLR = 1'b0;
`endif

  nx1_gram_beat_ctl #(
    .MAX_BEAT_WAIT(MAX_BEAT_WAIT)
  ) u_beat (
    .C_CLK    (C_CLK),
    .I_RESET_n(I_RESET_n),
    .start    (start_c),
    .beat     (beat_c),
    .ack      (I_GRAM_ACK),
    .req      (req),
    .beat_q   (beat_q),
    .done_c   (done_c),
    .tmo_c    (tmo_c)
  );

  // Lead term lets the CPU see WAIT in the strobe cycle itself
  assign O_WAIT     = wait_q | (LEAD_EN & (wr_acc_c | rd_acc_c) & I_RESET_n);
  assign O_Q        = q_q;
  assign O_Q_VLD    = q_vld_q;
  assign O_TMO      = tmo_q;
  assign O_GRAM_REQ = req;
  assign O_GRAM_WE  = beat_q.we;
  assign O_GRAM_A   = beat_q.a;
  assign O_GRAM_D   = beat_q.d;

endmodule

// File: tb/tb_nx1_gram_access.sv
// Bench for nx1_gram_access: transaction-level model plus directed scenarios.
module tb_nx1_gram_access;

  localparam int unsigned MAXW = 4;
  localparam bit          LEAD = 1'b1;
`ifdef NX1_DAM_CLR_ON_READ_EN
  localparam int DCLR = 1;
`else
  localparam int DCLR = 0;
`endif

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } bt_t;

  logic        C_CLK = 1'b0;
  logic        I_RESET_n = 1'b0;
  logic [15:0] I_A = '0;
  logic [7:0]  I_D = '0;
  logic        I_IOWR = 1'b0, I_IORD = 1'b0, I_DAM = 1'b0;
  logic        I_GRAM_ACK = 1'b0;
  logic [7:0]  I_GRAM_Q = '0;
  logic        O_WAIT, O_Q_VLD, O_DAM_CLR, O_GRAM_REQ, O_GRAM_WE, O_TMO;
  logic [7:0]  O_Q, O_GRAM_D;
  logic [15:0] O_GRAM_A;

  nx1_gram_access #(.MAX_BEAT_WAIT(MAXW), .WAIT_LEAD(1)) dut (
    .C_CLK(C_CLK), .I_RESET_n(I_RESET_n), .I_A(I_A), .I_D(I_D),
    .I_IOWR(I_IOWR), .I_IORD(I_IORD), .I_DAM(I_DAM), .O_WAIT(O_WAIT),
    .O_Q(O_Q), .O_Q_VLD(O_Q_VLD), .O_DAM_CLR(O_DAM_CLR),
    .O_GRAM_REQ(O_GRAM_REQ), .O_GRAM_WE(O_GRAM_WE), .O_GRAM_A(O_GRAM_A),
    .O_GRAM_D(O_GRAM_D), .I_GRAM_ACK(I_GRAM_ACK), .I_GRAM_Q(I_GRAM_Q),
    .O_TMO(O_TMO)
  );

  always #5 C_CLK = ~C_CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: ACK on the ack_dly-th cycle of each REQ, or never
  bit         ack_en = 1'b1;
  int         ack_dly = 0;
  int         req_cyc = 0;
  logic [7:0] rd_data = '0;
  always @(posedge C_CLK) begin
    #1;
    if (O_GRAM_REQ) begin
      I_GRAM_ACK = ack_en && (req_cyc == ack_dly);
      req_cyc++;
    end else begin
      I_GRAM_ACK = 1'b0;
      req_cyc = 0;
    end
    I_GRAM_Q = rd_data;
  end

  function automatic logic [2:0] spec_mask(input logic [1:0] area, input logic dam);
    case (area)
      2'd1:    return dam ? 3'b110 : 3'b001;
      2'd2:    return dam ? 3'b101 : 3'b010;
      2'd3:    return dam ? 3'b011 : 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Model state and observation logs
  bt_t        m_beats[$];
  bit         m_busy = 0, m_req = 0, m_done = 0, m_rd = 0, m_tmo = 0;
  bit         m_qvld = 0, m_dclr = 0;
  logic [7:0] m_q = '0;
  int         m_wait = 0;
  bt_t        act_log[$];
  int         wait_cnt = 0, req_cnt = 0, qvld_cnt = 0, dclr_cnt = 0;

  always @(negedge C_CLK) begin
    bit gram, acc_wr, acc_rd, exp_wait, nq, nd;
    logic [2:0] mask;
    logic [1:0] pl;
    bt_t bt;
    if (!I_RESET_n) begin
      m_beats.delete();
      m_busy = 0; m_req = 0; m_done = 0; m_rd = 0; m_tmo = 0;
      m_qvld = 0; m_dclr = 0; m_q = '0; m_wait = 0;
    end else begin
      gram     = (I_A[15:14] != 2'b00);
      acc_wr   = !m_busy && I_IOWR && gram;
      acc_rd   = !m_busy && !I_IOWR && I_IORD && gram;
      exp_wait = m_busy || (LEAD && (acc_wr || acc_rd));
      chk("wait", 32'(O_WAIT), 32'(exp_wait));
      chk("req", 32'(O_GRAM_REQ), 32'(m_req));
      chk("q_vld", 32'(O_Q_VLD), 32'(m_qvld));
      chk("q", 32'(O_Q), 32'(m_q));
      chk("tmo", 32'(O_TMO), 32'(m_tmo));
      chk("dam_clr", 32'(O_DAM_CLR), 32'(m_dclr));
      if (O_GRAM_REQ && m_req && m_beats.size() > 0) begin
        chk("beat_we", 32'(O_GRAM_WE), 32'(m_beats[0].we));
        chk("beat_a", 32'(O_GRAM_A), 32'(m_beats[0].a));
        if (m_beats[0].we) chk("beat_d", 32'(O_GRAM_D), 32'(m_beats[0].d));
      end
      if (O_WAIT) wait_cnt++;
      if (O_GRAM_REQ) req_cnt++;
      if (O_Q_VLD) qvld_cnt++;
      if (O_DAM_CLR) dclr_cnt++;
      if (O_GRAM_REQ && I_GRAM_ACK) act_log.push_back(bt_t'({O_GRAM_WE, O_GRAM_A, O_GRAM_D}));

      nq = 0; nd = 0;
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_busy) begin
        if (m_req) begin
          if (I_GRAM_ACK) begin
            if (m_rd) begin m_q = I_GRAM_Q; nq = 1; end
            void'(m_beats.pop_front());
            m_req = 0;
            if (m_beats.size() == 0) m_done = 1;
          end else begin
            m_wait++;
            if (MAXW != 0 && m_wait == int'(MAXW)) begin
              m_tmo = 1; m_req = 0; m_beats.delete(); m_done = 1;
              if (m_rd) begin m_q = 8'hFF; nq = 1; end
            end
          end
        end else begin
          m_req = 1; m_wait = 0;
        end
      end else if (acc_wr || acc_rd) begin
        mask = spec_mask(I_A[15:14], acc_wr ? I_DAM : 1'b0);
        for (int b = 0; b < 3; b++) begin
          if (mask[b]) begin
            pl = 2'(b + 1);
            bt.we = acc_wr; bt.a = {pl, I_A[13:0]}; bt.d = acc_wr ? I_D : 8'h00;
            m_beats.push_back(bt);
            if (acc_rd) break;
          end
        end
        m_busy = 1; m_req = 1; m_wait = 0; m_rd = acc_rd;
        nd = acc_rd && (DCLR != 0);
      end
      m_qvld = nq; m_dclr = nd;
    end
  end

  int b_wait, b_req, b_qvld, b_dclr, b_log;

  task automatic cyc();
    @(posedge C_CLK); #1;
  endtask

  task automatic snap();
    b_wait = wait_cnt; b_req = req_cnt; b_qvld = qvld_cnt; b_dclr = dclr_cnt;
    b_log = act_log.size();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic dam);
    cyc();
    I_A = a; I_D = d; I_DAM = dam; I_IOWR = 1'b1;
    cyc();
    I_IOWR = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    cyc();
    I_A = a; I_IORD = 1'b1;
    cyc();
    I_IORD = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge C_CLK);
    while (O_WAIT && n < 60) begin
      @(negedge C_CLK);
      n++;
    end
    chk({nm, "_idle"}, 32'(O_WAIT), 32'd0);
    cyc(); cyc();
  endtask

  task automatic chk_entry(input string nm, input int idx, input bit we,
                           input logic [15:0] a, input logic [7:0] d);
    int k = b_log + idx;
    if (k < act_log.size()) begin
      chk({nm, "_a"}, 32'(act_log[k].a), 32'(a));
      chk({nm, "_we"}, 32'(act_log[k].we), 32'(we));
      if (we) chk({nm, "_d"}, 32'(act_log[k].d), 32'(d));
    end else begin
      chk({nm, "_missing"}, 32'hFFFF_FFFF, 32'(a));
    end
  endtask

  initial begin
    int n;
    // Reset state
    #2;
    chk("rst_wait", 32'(O_WAIT), 0);
    chk("rst_req", 32'(O_GRAM_REQ), 0);
    chk("rst_a", 32'(O_GRAM_A), 0);
    chk("rst_q", 32'(O_Q), 0);
    chk("rst_tmo", 32'(O_TMO), 0);
    repeat (2) @(posedge C_CLK);
    #1 I_RESET_n = 1'b1;
    cyc();

    // Single write, ACK on third REQ cycle
    ack_dly = 2; snap();
    wr(16'h4123, 8'h5A, 1'b0);
    wait_idle("w1");
    chk("w1_beats", 32'(act_log.size() - b_log), 1);
    chk_entry("w1_b0", 0, 1'b1, 16'h4123, 8'h5A);
    chk("w1_waitcyc", 32'(wait_cnt - b_wait), 5);
    chk("w1_dclr", 32'(dclr_cnt - b_dclr), 0);

    // DAM write; I_DAM drops mid-sequence and must not matter
    ack_dly = 1; snap();
    wr(16'hC010, 8'h3C, 1'b1);
    I_DAM = 1'b0;
    wait_idle("w2");
    chk("w2_beats", 32'(act_log.size() - b_log), 2);
    chk_entry("w2_b0", 0, 1'b1, 16'h4010, 8'h3C);
    chk_entry("w2_b1", 1, 1'b1, 16'h8010, 8'h3C);
    chk("w2_waitcyc", 32'(wait_cnt - b_wait), 7);

    // Minimum latency, ACK on first REQ cycle
    ack_dly = 0; snap();
    wr(16'h4001, 8'hAA, 1'b0);
    wait_idle("w3");
    chk("w3_waitcyc", 32'(wait_cnt - b_wait), 3);
    snap();
    wr(16'h4002, 8'hBB, 1'b1);
    I_DAM = 1'b0;
    wait_idle("w4");
    chk("w4_waitcyc", 32'(wait_cnt - b_wait), 5);
    chk_entry("w4_b0", 0, 1'b1, 16'h8002, 8'hBB);
    chk_entry("w4_b1", 1, 1'b1, 16'hC002, 8'hBB);

    // Read
    ack_dly = 1; rd_data = 8'hA7; snap();
    rd(16'h8200);
    wait_idle("r1");
    chk_entry("r1_b0", 0, 1'b0, 16'h8200, 8'h00);
    chk("r1_q", 32'(O_Q), 32'hA7);
    chk("r1_qvld", 32'(qvld_cnt - b_qvld), 1);
    chk("r1_dclr", 32'(dclr_cnt - b_dclr), 32'(DCLR));
    chk("r1_waitcyc", 32'(wait_cnt - b_wait), 4);

    // Area 00 ignored for write and read
    snap();
    wr(16'h2000, 8'h12, 1'b1);
    I_DAM = 1'b0;
    rd(16'h0010);
    cyc(); cyc(); cyc();
    chk("a0_req", 32'(req_cnt - b_req), 0);
    chk("a0_wait", 32'(wait_cnt - b_wait), 0);

    // Strobe during a busy DAM write is dropped
    ack_dly = 2; snap();
    wr(16'h4100, 8'h11, 1'b1);
    I_DAM = 1'b0;
    cyc();
    I_A = 16'h4200; I_D = 8'h99; I_IOWR = 1'b1;
    cyc();
    I_IOWR = 1'b0;
    wait_idle("d1");
    cyc(); cyc();
    chk("d1_beats", 32'(act_log.size() - b_log), 2);
    chk_entry("d1_b0", 0, 1'b1, 16'h8100, 8'h11);
    chk_entry("d1_b1", 1, 1'b1, 16'hC100, 8'h11);

    // Simultaneous write and read: write wins
    ack_dly = 0; snap();
    cyc();
    I_A = 16'h8005; I_D = 8'h77; I_IOWR = 1'b1; I_IORD = 1'b1;
    cyc();
    I_IOWR = 1'b0; I_IORD = 1'b0;
    wait_idle("s1");
    chk("s1_beats", 32'(act_log.size() - b_log), 1);
    chk_entry("s1_b0", 0, 1'b1, 16'h8005, 8'h77);
    chk("s1_qvld", 32'(qvld_cnt - b_qvld), 0);

    // Timeout on a read
    ack_en = 1'b0; snap();
    rd(16'h4300);
    wait_idle("t1");
    chk("t1_reqcyc", 32'(req_cnt - b_req), MAXW);
    chk("t1_tmo", 32'(O_TMO), 1);
    chk("t1_q", 32'(O_Q), 32'hFF);
    chk("t1_qvld", 32'(qvld_cnt - b_qvld), 1);
    chk("t1_waitcyc", 32'(wait_cnt - b_wait), 6);
    ack_en = 1'b1;

    // Reset during the second DAM beat
    ack_dly = 2; snap();
    wr(16'hC020, 8'h55, 1'b1);
    I_DAM = 1'b0;
    n = 0;
    while (!(act_log.size() > b_log && O_GRAM_REQ) && n < 30) begin
      @(negedge C_CLK);
      n++;
    end
    chk("rm_second_beat", 32'(O_GRAM_REQ), 1);
    @(posedge C_CLK);
    #3 I_RESET_n = 1'b0;
    #1;
    chk("rm_req", 32'(O_GRAM_REQ), 0);
    chk("rm_wait", 32'(O_WAIT), 0);
    chk("rm_tmo", 32'(O_TMO), 0);
    repeat (2) @(posedge C_CLK);
    #1 I_RESET_n = 1'b1;
    snap();
    repeat (8) cyc();
    chk("rm_noreq", 32'(req_cnt - b_req), 0);
    chk("rm_nowait", 32'(wait_cnt - b_wait), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/nx1_gram_access.md
Name: nx1_gram_access

Overview:
- Graphic-VRAM (GRAM) I/O access sequencer for the X1 core. It sits between the Z80 I/O write/read strobes and the single-port GRAM memory controller.
- It consumes the DAM (simultaneous access mode) flag produced by the mode/switch block. In DAM mode it expands one CPU write into two serial plane writes. It issues the DAM-clear request back to the mode block on GRAM reads.
- It stalls the CPU via O_WAIT while beats are outstanding.

Parameters:
- MAX_BEAT_WAIT, 255, cycles a beat may wait for I_GRAM_ACK before abort; 0 = no timeout.
- WAIT_LEAD, 1, 1 = O_WAIT asserted combinationally in the strobe cycle; 0 = from the next cycle.

Ports:
- C_CLK  in  1  system clock
- I_RESET_n  in  1  asynchronous active-low reset
- I_A  in  16  CPU I/O address
- I_D  in  8  CPU write data
- I_IOWR  in  1  one-cycle I/O write strobe
- I_IORD  in  1  one-cycle I/O read strobe
- I_DAM  in  1  DAM mode flag from mode block
- O_WAIT  out  1  CPU wait request
- O_Q  out  8  read data to CPU bus mux
- O_Q_VLD  out  1  one-cycle pulse, O_Q updated
- O_DAM_CLR  out  1  one-cycle DAM-clear pulse to mode block
- O_GRAM_REQ  out  1  memory request, held until acked
- O_GRAM_WE  out  1  1 = write beat, 0 = read beat
- O_GRAM_A  out  16  {plane[1:0], I_A[13:0]}; plane codes B=01, R=10, G=11
- O_GRAM_D  out  8  write data
- I_GRAM_ACK  in  1  one-cycle beat completion
- I_GRAM_Q  in  8  read data, valid in the I_GRAM_ACK cycle
- O_TMO  out  1  sticky timeout flag, cleared by reset only

Behaviour:
- Reset values (async, I_RESET_n low): all outputs 0; state IDLE; beat mask 000.
- Decode uses area = I_A[15:14]. Area 00 is not GRAM: strobes are ignored, no wait, no request.
- Plane mask bits are {G,R,B}.
  - Write, I_DAM=0: area 01→B, 10→R, 11→G.
  - Write, I_DAM=1: area 01→R+G, 10→B+G, 11→B+R.
  - Read: always a single plane per area; I_DAM is ignored.
- I_DAM is sampled only in the strobe cycle. A DAM change mid-sequence does not alter the latched mask.
- States:
  - IDLE: on a GRAM I_IOWR, latch address, data and mask, go to WBEAT. On a GRAM I_IORD, latch address, go to RBEAT.
  - WBEAT: O_GRAM_REQ=1, O_GRAM_WE=1, plane = lowest set mask bit, in order B, R, G. On I_GRAM_ACK, clear that mask bit. If the mask is now empty go to DONE, else next plane from the following cycle.
  - RBEAT: O_GRAM_REQ=1, O_GRAM_WE=0. On ACK, O_Q<=I_GRAM_Q and go to DONE.
  - DONE: one cycle. O_Q_VLD=1 if the operation was a read. Then return to IDLE.
- Request rules:
  - REQ drops in the cycle after ACK for at least one cycle between beats.
  - Address, data and WE are stable while REQ is high.
- Wait timing:
  - O_WAIT=1 from the strobe cycle (WAIT_LEAD=1) or the cycle after it (WAIT_LEAD=0) through DONE inclusive.
  - Minimum latency: DAM write with ACK on the first REQ cycle = 5 cycles strobe→IDLE; single write = 3 cycles.
- Strobes arriving while not IDLE are dropped; the CPU must honour O_WAIT. A simultaneous I_IOWR and I_IORD gives the write priority and drops the read.
- Timeout: a per-beat counter, 8 bits, saturating. If it reaches MAX_BEAT_WAIT (≠0) without ACK: drop REQ, set O_TMO, discard the remaining mask, go to DONE; a read returns O_Q=FF.
- Reset mid-sequence: immediate abort. REQ and WAIT go low asynchronously, and no further beats are issued.

Optional Feature:
- Macro NX1_DAM_CLR_ON_READ_EN.
- Defined: O_DAM_CLR pulses for one cycle in the cycle after the strobe of every accepted GRAM read, independent of the ACK.
- Undefined: O_DAM_CLR tied 0; DAM clearing is left to the mode block's own decode.

Decomposition:
- Shared package nx1_pkg:
  - plane codes PL_B/PL_R/PL_G
  - area-to-mask tables for normal and DAM writes
  - state encoding typedef
- Natural sub-module: nx1_gram_beat_ctl, holding the REQ/ACK handshake and timeout counter for one beat. It is reused per write plane and for reads.

Test Plan:
- I_DAM=0, write A=4123 D=5A, ACK 2 cycles after REQ -> one beat with O_GRAM_A=4123, D=5A; O_WAIT high until DONE; no O_DAM_CLR.
- I_DAM=1, write A=C010 D=3C -> two beats in order: O_GRAM_A=4010 (B) then 8010 (R), both D=3C; O_WAIT spans both.
- Read A=8200 with I_GRAM_Q=A7 at ACK -> O_GRAM_A=8200, WE=0; O_Q=A7 with one O_Q_VLD pulse; O_DAM_CLR pulses only if the macro is defined.
- I_GRAM_ACK held 0, MAX_BEAT_WAIT=4 -> REQ drops after 4 cycles; O_TMO=1; a read returns FF.
- Write to A=2000, then a second I_IOWR during a busy DAM write -> no REQ for either; the dropped strobe produces no extra beat.
- Assert I_RESET_n low during the second DAM beat -> REQ, WAIT and O_TMO go 0 asynchronously; after release, IDLE with no residual beat.
